rv32_decode_stage: RTL and testbench



---
 rtl/rv32_pkg.sv | 55 +++++
 rtl/rv32_opcode_decode.sv | 46 ++++
 rtl/rv32_decode_stage.sv | 160 ++++++++++++++++
 tb/tb_rv32_decode_stage.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_pkg
//  Description : Shared RV32 decode types. Holds the instruction word type,
//                the immediate-format enumeration, the base opcode values and
//                the decode-stage packet used for the main and skid registers.
//  Revision    : 1.0  initial release
// ============================================================================
package rv32_pkg;

    // Width of the pc field carried in a decode packet.
    localparam int RV32_XLEN = 32;

    typedef logic [31:0] rv32_instr_t;

    // Immediate format of an instruction; R-type carries no immediate.
    typedef enum logic [2:0] {
        RV32_TYPE_R = 3'd0,
        RV32_TYPE_I = 3'd1,
        RV32_TYPE_S = 3'd2,
        RV32_TYPE_B = 3'd3,
        RV32_TYPE_U = 3'd4,
        RV32_TYPE_J = 3'd5
    } rv32_type_enum_t;

    // Base opcodes, instr[6:0].
    localparam logic [6:0] RV32_OPC_LUI      = 7'b0110111;
    localparam logic [6:0] RV32_OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] RV32_OPC_JAL      = 7'b1101111;
    localparam logic [6:0] RV32_OPC_JALR     = 7'b1100111;
    localparam logic [6:0] RV32_OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] RV32_OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] RV32_OPC_STORE    = 7'b0100011;
    localparam logic [6:0] RV32_OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] RV32_OPC_OP       = 7'b0110011;
    localparam logic [6:0] RV32_OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] RV32_OPC_SYSTEM   = 7'b1110011;

    // One buffered, already-decoded instruction.
    typedef struct packed {
        rv32_instr_t           instr;
        logic [RV32_XLEN-1:0]  pc;
        rv32_type_enum_t       imm_type;
        logic [4:0]            rd;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic                  illegal;
    } rv32_id_pkt_t;

    function automatic logic [6:0] rv32_opcode(input rv32_instr_t instr);
        return instr[6:0];
    endfunction

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/rv32_opcode_decode.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_opcode_decode
//  Description : Purely combinational opcode classifier. Maps an RV32 base
//                instruction to its immediate format and flags encodings that
//                are not supported (compressed space or unknown opcode).
//  Ports       : instr    in   instruction word
//                imm_type out  immediate format (I when illegal)
//                illegal  out  unsupported encoding
//  Revision    : 1.0  initial release
// ============================================================================
module rv32_opcode_decode
    import rv32_pkg::*;
(
    input  rv32_instr_t     instr,
    output rv32_type_enum_t imm_type,
    output logic            illegal
);

    always_comb begin
        imm_type = RV32_TYPE_I;
        illegal  = 1'b0;
        // Anything outside the 32-bit encoding space is rejected up front,
        // whatever its opcode bits happen to look like.
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (rv32_opcode(instr))
                RV32_OPC_LUI,
                RV32_OPC_AUIPC:    imm_type = RV32_TYPE_U;
                RV32_OPC_JAL:      imm_type = RV32_TYPE_J;
                RV32_OPC_BRANCH:   imm_type = RV32_TYPE_B;
                RV32_OPC_STORE:    imm_type = RV32_TYPE_S;
                RV32_OPC_JALR,
                RV32_OPC_LOAD,
                RV32_OPC_OP_IMM,
                RV32_OPC_MISC_MEM,
                RV32_OPC_SYSTEM:   imm_type = RV32_TYPE_I;
                RV32_OPC_OP:       imm_type = RV32_TYPE_R;
                default:           illegal  = 1'b1;
            endcase
        end
    end

endmodule : rv32_opcode_decode
`default_nettype wire

// File: rtl/rv32_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_decode_stage
//  Description : IF->ID pipeline stage with a 2-entry skid buffer. Incoming
//                instructions are classified before registering so the main
//                register directly presents instr, pc, immediate format and
//                register fields. if_ready is a flop output with no path from
//                id_ready, yet full throughput is kept with id_ready high.
//  Ports       : clk, rst_n              clock, async active-low reset
//                flush                   drop all buffered and incoming instrs
//                if_valid/if_ready       fetch-side handshake
//                if_instr/if_pc          fetched instruction and its pc
//                id_valid/id_ready       downstream handshake
//                id_instr/id_pc          instruction and pc to later stages
//                id_imm_type             immediate format
//                id_rd/id_rs1/id_rs2     register fields
//                id_illegal              unsupported encoding
//  Revision    : 1.0  initial release
// ============================================================================
module rv32_decode_stage
    import rv32_pkg::*;
#(
    // The packet pc field is RV32_XLEN wide; XLEN is expected to match it.
    parameter int          XLEN        = 32,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output rv32_type_enum_t id_imm_type,
    output logic [4:0]      id_rd,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic            id_illegal
);

    // Contents held in both data registers while reset is asserted: a nop
    // at pc 0, so downstream sees a harmless instruction even if it looks.
    localparam rv32_id_pkt_t c_reset_pkt = '{
        instr:    RESET_INSTR,
        pc:       '0,
        imm_type: RV32_TYPE_I,
        rd:       RESET_INSTR[11:7],
        rs1:      RESET_INSTR[19:15],
        rs2:      RESET_INSTR[24:20],
        illegal:  1'b0
    };

    rv32_id_pkt_t    r_main;
    rv32_id_pkt_t    r_skid;
    logic            r_main_valid;
    logic            r_skid_valid;
    logic            r_if_ready;

    rv32_id_pkt_t    w_main_nxt;
    rv32_id_pkt_t    w_skid_nxt;
    logic            w_main_valid_nxt;
    logic            w_skid_valid_nxt;

    rv32_id_pkt_t    w_in_pkt;
    rv32_type_enum_t w_in_type;
    logic            w_in_illegal;
    logic            w_accept;
    logic            w_fire;

    // ------------------------------------------------------------------
    // Decode the incoming word so buffered entries are already classified.
    // ------------------------------------------------------------------
    rv32_opcode_decode u_opcode_decode (
        .instr    (if_instr),
        .imm_type (w_in_type),
        .illegal  (w_in_illegal)
    );

    always_comb begin
        w_in_pkt.instr    = if_instr;
        w_in_pkt.pc       = if_pc;
        w_in_pkt.imm_type = w_in_type;
        w_in_pkt.rd       = if_instr[11:7];
        w_in_pkt.rs1      = if_instr[19:15];
        w_in_pkt.rs2      = if_instr[24:20];
        w_in_pkt.illegal  = w_in_illegal;
    end

    assign w_accept = if_valid & r_if_ready;
    assign w_fire   = r_main_valid & id_ready;

    // ------------------------------------------------------------------
    // Buffer next-state. The skid entry is always older than the incoming
    // one, so it is drained into main first; an accept can only coincide
    // with an empty skid because if_ready is low whenever skid is full.
    // Data registers are left untouched when an entry is dropped, so the
    // id_* payload never moves except on a load.
    // ------------------------------------------------------------------
    always_comb begin
        w_main_nxt       = r_main;
        w_skid_nxt       = r_skid;
        w_main_valid_nxt = r_main_valid;
        w_skid_valid_nxt = r_skid_valid;

        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (!r_main_valid || w_fire) begin
            if (r_skid_valid) begin
                w_main_nxt       = r_skid;
                w_main_valid_nxt = 1'b1;
                w_skid_valid_nxt = 1'b0;
            end else if (w_accept) begin
                w_main_nxt       = w_in_pkt;
                w_main_valid_nxt = 1'b1;
            end else begin
                w_main_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_nxt       = w_in_pkt;
            w_skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main       <= c_reset_pkt;
            r_skid       <= c_reset_pkt;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_if_ready   <= 1'b1;
        end else begin
            r_main       <= w_main_nxt;
            r_skid       <= w_skid_nxt;
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            // Registered copy of "skid empty" so if_ready leaves a flop.
            r_if_ready   <= ~w_skid_valid_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs come straight from the main register.
    // ------------------------------------------------------------------
    assign if_ready    = r_if_ready;
    assign id_valid    = r_main_valid;
    assign id_instr    = r_main.instr;
    assign id_pc       = r_main.pc;
    assign id_imm_type = r_main.imm_type;
    assign id_rd       = r_main.rd;
    assign id_rs1      = r_main.rs1;
    assign id_rs2      = r_main.rs2;
    assign id_illegal  = r_main.illegal;

endmodule : rv32_decode_stage
`default_nettype wire

// File: tb/tb_rv32_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32_decode_stage
//  Description : Self-checking bench for rv32_decode_stage. Directed steps in
//                one initial block; an output scoreboard built from accepted
//                inputs and an independent opcode reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rv32_decode_stage;
    import rv32_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [31:0]     if_pc;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_instr;
    logic [31:0]     id_pc;
    rv32_type_enum_t id_imm_type;
    logic [4:0]      id_rd;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic            id_illegal;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  typ;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    rv32_decode_stage #(
        .XLEN        (32),
        .RESET_INSTR (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_imm_type (id_imm_type),
        .id_rd       (id_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_illegal  (id_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference classifier: returns {type, illegal}.
    function automatic logic [3:0] ref_dec(input logic [31:0] x);
        if (x[1:0] != 2'b11) return {RV32_TYPE_I, 1'b1};
        case (x[6:0])
            7'h37, 7'h17:                      return {RV32_TYPE_U, 1'b0};
            7'h6F:                             return {RV32_TYPE_J, 1'b0};
            7'h63:                             return {RV32_TYPE_B, 1'b0};
            7'h23:                             return {RV32_TYPE_S, 1'b0};
            7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: return {RV32_TYPE_I, 1'b0};
            7'h33:                             return {RV32_TYPE_R, 1'b0};
            default:                           return {RV32_TYPE_I, 1'b1};
        endcase
    endfunction

    // Scoreboard: pop on fire, clear on flush/reset, push on accept.
    always @(negedge clk) begin
        exp_t e;
        logic [3:0] d;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (id_valid && id_ready) begin
                check("sb_nonempty_on_fire", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("sb_instr", id_instr, e.instr);
                    check("sb_pc", id_pc, e.pc);
                    check("sb_type", id_imm_type, e.typ);
                    check("sb_illegal", id_illegal, e.ill);
                    check("sb_fields", {id_rd, id_rs1, id_rs2},
                          {e.instr[11:7], e.instr[19:15], e.instr[24:20]});
                end
            end
            if (flush) begin
                sb.delete();
            end else if (if_valid && if_ready) begin
                d = ref_dec(if_instr);
                e.instr = if_instr;
                e.pc    = if_pc;
                e.typ   = d[3:1];
                e.ill   = d[0];
                sb.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] stream [8];
        logic [31:0] ill_tbl [3];
        stream[0] = 32'h0010_0093;  // addi
        stream[1] = 32'h0020_8133;  // add
        stream[2] = 32'h0000_1237;  // lui
        stream[3] = 32'h0000_0297;  // auipc
        stream[4] = 32'h0000_036F;  // jal
        stream[5] = 32'h0041_2023;  // sw
        stream[6] = 32'h0000_A383;  // lw
        stream[7] = 32'h0000_0463;  // beq
        ill_tbl[0] = 32'h0000_0000;
        ill_tbl[1] = 32'h0000_0057;
        ill_tbl[2] = 32'h0000_006F;

        rst_n    = 1'b1;
        flush    = 1'b0;
        if_valid = 1'b0;
        if_instr = '0;
        if_pc    = '0;
        id_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        // Reset state
        check("rst_id_valid", id_valid, 0);
        check("rst_if_ready", if_ready, 1);
        check("rst_id_instr", id_instr, 32'h0000_0013);
        check("rst_id_pc", id_pc, 0);
        check("rst_imm_type", id_imm_type, RV32_TYPE_I);
        check("rst_illegal", id_illegal, 0);
        #10 rst_n = 1'b1;
        step();

        // Single LUI, one-cycle latency
        id_ready = 1'b1;
        drive(32'h1234_50B7, 32'h100);
        step();
        if_valid = 1'b0;
        check("lui_valid", id_valid, 1);
        check("lui_type", id_imm_type, RV32_TYPE_U);
        check("lui_rd", id_rd, 5'd1);
        check("lui_pc", id_pc, 32'h100);
        check("lui_illegal", id_illegal, 0);
        step();
        check("lui_drained", id_valid, 0);

        // Back-to-back stream at full rate
        for (int i = 0; i < 8; i++) begin
            drive(stream[i], 32'h200 + 32'(i * 4));
            step();
            check("stream_valid", id_valid, 1);
            check("stream_order", id_instr, stream[i]);
            check("stream_if_ready", if_ready, 1);
        end
        if_valid = 1'b0;
        step();
        check("stream_drained", id_valid, 0);

        // Backpressure: BEQ held in main, SW in skid
        id_ready = 1'b0;
        drive(32'h0020_8463, 32'h300);
        step();
        check("bp_beq_type", id_imm_type, RV32_TYPE_B);
        check("bp_beq_rs", {id_rs1, id_rs2}, {5'd1, 5'd2});
        check("bp_ready1", if_ready, 1);
        drive(32'h0011_2223, 32'h304);
        step();
        if_valid = 1'b0;
        check("bp_ready_low", if_ready, 0);
        check("bp_hold_instr", id_instr, 32'h0020_8463);
        step();
        check("bp_hold_pc", id_pc, 32'h300);
        check("bp_hold_valid", id_valid, 1);
        check("bp_ready_low2", if_ready, 0);
        id_ready = 1'b1;
        step();
        check("bp_sw_instr", id_instr, 32'h0011_2223);
        check("bp_sw_type", id_imm_type, RV32_TYPE_S);
        check("bp_ready_back", if_ready, 1);
        step();
        check("bp_drained", id_valid, 0);

        // Flush with both entries full and fetch valid
        id_ready = 1'b0;
        drive(32'h0000_0013, 32'h400);
        step();
        drive(32'h0010_0093, 32'h404);
        step();
        check("fl_skid_full", if_ready, 0);
        drive(32'h0020_0113, 32'h408);
        flush = 1'b1;
        step();
        check("fl_valid", id_valid, 0);
        check("fl_ready", if_ready, 1);
        // Same-cycle accept during flush is dropped too
        step();
        flush    = 1'b0;
        if_valid = 1'b0;
        id_ready = 1'b1;
        check("fl_drop_accept", id_valid, 0);
        step();
        check("fl_nothing_back", id_valid, 0);

        // Illegal encodings and JAL
        for (int i = 0; i < 3; i++) begin
            drive(ill_tbl[i], 32'h500 + 32'(i * 4));
            step();
            check("ill_type", id_imm_type, (i == 2) ? RV32_TYPE_J : RV32_TYPE_I);
            check("ill_flag", id_illegal, (i == 2) ? 1'b0 : 1'b1);
        end
        if_valid = 1'b0;
        step();

        // Asynchronous reset with skid full
        id_ready = 1'b0;
        drive(32'h0010_0093, 32'h600);
        step();
        drive(32'h0000_0297, 32'h604);
        step();
        if_valid = 1'b0;
        check("ar_skid_full", if_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", id_valid, 0);
        check("ar_ready", if_ready, 1);
        check("ar_instr", id_instr, 32'h0000_0013);
        check("ar_pc", id_pc, 0);
        #3 rst_n = 1'b1;
        step();
        check("ar_after_valid", id_valid, 0);

        // Recovery after reset
        id_ready = 1'b1;
        drive(32'h0000_0033, 32'h700);
        step();
        if_valid = 1'b0;
        check("rec_valid", id_valid, 1);
        check("rec_type", id_imm_type, RV32_TYPE_R);
        step();
        step();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_rv32_decode_stage
`default_nettype wire
